// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder: in-order fixed-latency instruction memory responder with backdoor load and grant stall
module ibex_instr_mem_responder #(
  parameter int          Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     instr_req_i,
  output logic                     instr_gnt_o,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     stall_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  output logic                     busy_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] Lo = {1'b0, BaseAddr};
  localparam logic [32:0] Hi = Lo + 33'(Depth) * 33'd4;
  logic [31:0]        mem [Depth];
  logic [CW-1:0]      cnt_q;
  logic [Latency-1:0] pv_q, pe_q;
  logic [31:0]        pd_q [Latency];
  logic               in_range;
  logic [AW-1:0]      idx;
  assign in_range       = ({1'b0, instr_addr_i} >= Lo) && ({1'b0, instr_addr_i} < Hi);
  assign idx            = instr_addr_i[AW+1:2];
  assign instr_gnt_o    = instr_req_i & ~stall_i & (cnt_q < CW'(MaxOutstanding));
  assign instr_rvalid_o = pv_q[Latency-1];
  assign instr_err_o    = pv_q[Latency-1] & pe_q[Latency-1];
  assign instr_rdata_o  = pv_q[Latency-1] ? pd_q[Latency-1] : '0;
  assign busy_o         = cnt_q != '0;
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  // the grant-cycle read sees the pre-write word, giving read-before-write on collision
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      pv_q  <= '0;
      pe_q  <= '0;
      for (int i = 0; i < Latency; i++) pd_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_q + CW'(instr_gnt_o) - CW'(instr_rvalid_o);
      pv_q[0] <= instr_gnt_o;
      pe_q[0] <= instr_gnt_o & ~in_range;
      pd_q[0] <= (instr_gnt_o && in_range) ? mem[idx] : '0;
      for (int i = 1; i < Latency; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CW'(MaxOutstanding) && !(cnt_q == '0 && instr_rvalid_o));
endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// tb_ibex_instr_mem_responder: directed checks of fetch latency, backpressure, range errors, collisions and reset
module tb_ibex_instr_mem_responder;
  logic        clk = 0, rst_n = 0, stall = 0, we = 0;
  logic        req_a = 0, req_b = 0, req_c = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [9:0]  waddr = 0;
  logic        gnt_a, rv_a, err_a, busy_a, gnt_b, rv_b, err_b, busy_b, gnt_c, rv_c, err_c, busy_c;
  logic [31:0] rd_a, rd_b, rd_c;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h1000), .Latency(1), .MaxOutstanding(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_a), .instr_gnt_o(gnt_a), .instr_addr_i(addr),
    .instr_rvalid_o(rv_a), .instr_rdata_o(rd_a), .instr_err_o(err_a), .stall_i(stall),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy_a));
  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_b), .instr_gnt_o(gnt_b), .instr_addr_i(addr),
    .instr_rvalid_o(rv_b), .instr_rdata_o(rd_b), .instr_err_o(err_b), .stall_i(stall),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy_b));
  ibex_instr_mem_responder #(.Depth(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_c), .instr_gnt_o(gnt_c), .instr_addr_i(addr),
    .instr_rvalid_o(rv_c), .instr_rdata_o(rd_c), .instr_err_o(err_c), .stall_i(stall),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .busy_o(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  initial begin
    logic [31:0] seq [4];
    logic [31:0] oaddr [3];
    logic [2:0]  oerr;
    logic [31:0] odata [3];
    logic [9:0]  bg, brv, bbusy;
    logic [12:0] sst, sg, srv, sbusy;
    seq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    tick();
    chk("rst_rvalid", {31'b0, rv_a}, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_err", {31'b0, err_a}, 0);
    chk("rst_busy", {31'b0, busy_a}, 0);
    req_a = 1; #1;
    chk("rst_gnt_eq", {31'b0, gnt_a}, 1);
    req_a = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) wr(10'(i), seq[i]);
    wr(10'd1023, 32'h0BADF00D);
    wr(10'd5, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      req_a = i < 4; addr = 32'h1000 + 32'(4 * i); #1;
      chk($sformatf("b2b_gnt%0d", i), {31'b0, gnt_a}, {31'b0, i < 4});
      chk($sformatf("b2b_rv%0d", i), {31'b0, rv_a}, {31'b0, i > 0});
      if (i > 0) begin
        chk($sformatf("b2b_rd%0d", i), rd_a, seq[i-1]);
        chk($sformatf("b2b_err%0d", i), {31'b0, err_a}, 0);
      end
      tick();
    end
    chk("b2b_idle_rv", {31'b0, rv_a}, 0);
    chk("b2b_idle_busy", {31'b0, busy_a}, 0);
    oaddr = '{32'h0FFC, 32'h2000, 32'h1FFC};
    oerr  = 3'b011;
    odata = '{32'h0, 32'h0, 32'h0BADF00D};
    for (int i = 0; i < 4; i++) begin
      req_a = i < 3; if (i < 3) addr = oaddr[i]; #1;
      if (i > 0) begin
        chk($sformatf("rng_rv%0d", i), {31'b0, rv_a}, 1);
        chk($sformatf("rng_err%0d", i), {31'b0, err_a}, {31'b0, oerr[i-1]});
        chk($sformatf("rng_rd%0d", i), rd_a, odata[i-1]);
      end
      tick();
    end
    req_a = 1; addr = 32'h1014; we = 1; waddr = 5; wdata = 32'hCAFEF00D; #1;
    chk("col_gnt", {31'b0, gnt_a}, 1);
    tick();
    we = 0; #1;
    chk("col_old", rd_a, 32'hDEADBEEF);
    tick();
    req_a = 0; #1;
    chk("col_new", rd_a, 32'hCAFEF00D);
    tick();
    addr = 0;
    bg = 10'b0000110011; brv = 10'b0110011000; bbusy = 10'b0111111110;
    for (int c = 0; c < 10; c++) begin
      req_b = c < 7; #1;
      chk($sformatf("lat_gnt%0d", c), {31'b0, gnt_b}, {31'b0, bg[c]});
      chk($sformatf("lat_rv%0d", c), {31'b0, rv_b}, {31'b0, brv[c]});
      chk($sformatf("lat_busy%0d", c), {31'b0, busy_b}, {31'b0, bbusy[c]});
      chk($sformatf("lat_rd%0d", c), rd_b, brv[c] ? 32'h11111111 : 32'h0);
      tick();
    end
    sst = 13'b0_0000_0111_1100; sg = 13'b0_0001_1000_0011;
    srv = 13'b0_1100_0001_1000; sbusy = 13'b0_1111_0001_1110;
    for (int s = 0; s < 13; s++) begin
      req_b = s < 9; stall = sst[s]; #1;
      chk($sformatf("stl_gnt%0d", s), {31'b0, gnt_b}, {31'b0, sg[s]});
      chk($sformatf("stl_rv%0d", s), {31'b0, rv_b}, {31'b0, srv[s]});
      chk($sformatf("stl_busy%0d", s), {31'b0, busy_b}, {31'b0, sbusy[s]});
      tick();
    end
    stall = 0; req_b = 0;
    req_c = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rstf_gnt%0d", c), {31'b0, gnt_c}, 1);
      tick();
    end
    req_c = 0; #1;
    chk("rstf_busy_pre", {31'b0, busy_c}, 1);
    rst_n = 0; #1;
    chk("rstf_rv", {31'b0, rv_c}, 0);
    chk("rstf_busy", {31'b0, busy_c}, 0);
    chk("rstf_rd", rd_c, 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rstf_stale%0d", c), {31'b0, rv_c}, 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
